uart_rx_fifo: RTL and testbench

- Standalone 8N1 UART receiver with a show-ahead byte FIFO.
- Sits directly downstream of a UART transmit pin, for example uart_0_external_connection_txd of the Qsys uart system. Used for loopback checking and for driving a host-side/LED command path.
- Oversamples the line at 16x baud, rejects start-bit glitches, detects framing and overrun errors, and buffers received bytes for a simple pop interface.

---
 rtl/uart_rx_fifo_if.sv | 24 ++
 rtl/uart_rx_fifo.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Read-side bus of uart_rx_fifo: pop handshake, FIFO status and sticky error flags.
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [CW-1:0] fifo_count;
  logic          frame_err;
  logic          overrun_err;
  logic          clr_err;

  modport master (
    output rd_en, clr_err,
    input  rd_data, rd_valid, fifo_count, frame_err, overrun_err
  );

  modport slave (
    input  rd_en, clr_err,
    output rd_data, rd_valid, fifo_count, frame_err, overrun_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver, 16x oversampled with 2-of-3 majority voting, feeding a
// show-ahead byte FIFO with sticky framing/overrun flags.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line idle, waiting for a 1->0 edge on rxd_s
// ST_START | validating the start bit; a high majority is a glitch
// ST_DATA  | shifting 8 data bits in, LSB first
// ST_STOP  | sampling the stop bit; high pushes the byte, low is an error
// ST_BREAK | line held low after a bad stop; wait for one high tick
module uart_rx_fifo #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  input  logic          rxd,
  uart_rx_fifo_if.slave rd_bus
);
  localparam int OSR_DIV = CLK_HZ / (BAUD * 16);
  localparam int TW      = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_t;

  state_t         state_q, state_d;
  logic           rxd_m, rxd_s, rxd_d;
  logic [TW-1:0]  tick_cnt;
  logic           tick;
  logic [3:0]     phase;
  logic           s7, s8, maj;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           push, frame_set;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count_q;
  logic           pop, full, push_ok, overrun_set;
  logic           frame_err_q, overrun_err_q;

  assign tick = (state_q != ST_IDLE) && (tick_cnt == TW'(OSR_DIV - 1));
  assign maj  = (s7 & s8) | (s7 & rxd_s) | (s8 & rxd_s);

  // Two-flop synchronizer plus a delayed copy for start-edge detection.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_d <= rxd_s;
    end
  end

  // Oversample tick divider; in BREAK any low sample restarts it so a tick means a full high tick.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)
      tick_cnt <= '0;
    else if (state_q == ST_IDLE || tick || (state_q == ST_BREAK && !rxd_s))
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + TW'(1);
  end

  // Bit phase, majority samples, bit index and data shift register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      phase   <= '0;
      s7      <= 1'b1;
      s8      <= 1'b1;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (state_q == ST_IDLE)
        phase <= '0;
      else if (tick)
        phase <= phase + 4'd1;
      if (tick && phase == 4'd7)
        s7 <= rxd_s;
      if (tick && phase == 4'd8)
        s8 <= rxd_s;
      if (state_q == ST_START)
        bit_idx <= '0;
      else if (state_q == ST_DATA && tick && phase == 4'd15)
        bit_idx <= bit_idx + 3'd1;
      if (state_q == ST_DATA && tick && phase == 4'd9)
        shreg <= {maj, shreg[7:1]};
    end
  end

  // FSM state register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // FSM next state, byte push and framing-error strobe.
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      ST_IDLE:
        if (rxd_d && !rxd_s) state_d = ST_START;
      ST_START:
        if (tick) begin
          if (phase == 4'd9 && maj)  state_d = ST_IDLE;
          else if (phase == 4'd15)   state_d = ST_DATA;
        end
      ST_DATA:
        if (tick && phase == 4'd15 && bit_idx == 3'd7) state_d = ST_STOP;
      ST_STOP:
        if (tick && phase == 4'd9) begin
          if (maj) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = ST_BREAK;
          end
        end
      ST_BREAK:
        if (tick) state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  assign pop         = rd_bus.rd_en && (count_q != '0);
  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign push_ok     = push && (!full || pop);
  assign overrun_set = push && full && !pop;

  // FIFO storage; contents need no reset because reads are gated by the count.
  always_ff @(posedge clk_clk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; a new event in the same cycle as clr_err wins.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      if (frame_set)           frame_err_q <= 1'b1;
      else if (rd_bus.clr_err) frame_err_q <= 1'b0;
      if (overrun_set)         overrun_err_q <= 1'b1;
      else if (rd_bus.clr_err) overrun_err_q <= 1'b0;
    end
  end

  assign rd_bus.rd_valid    = (count_q != '0);
  assign rd_bus.rd_data     = (count_q != '0) ? mem[rd_ptr] : 8'h00;
  assign rd_bus.fifo_count  = count_q;
  assign rd_bus.frame_err   = frame_err_q;
  assign rd_bus.overrun_err = overrun_err_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a fast-baud instance (OSR_DIV=3) for most scenarios
// and a default-parameter instance for the 115200 baud reception check.
module tb_uart_rx_fifo;
  localparam int A_CLK_HZ = 4800000;
  localparam int A_BAUD   = 100000;
  localparam int BIT_A    = A_CLK_HZ / A_BAUD;
  localparam int BIT_B    = 50000000 / 115200;
  localparam int DEPTH    = 16;

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    logic       do_pop;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_count;
    logic       exp_frame;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rxd_a = 1'b1;
  logic rxd_b = 1'b1;

  int checks = 0;
  int errors = 0;
  int lat_a  = 0;
  logic [7:0] mq[$];
  logic m_frame, m_over;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus_a ();
  uart_rx_fifo_if #(.FIFO_DEPTH(16))    bus_b ();

  uart_rx_fifo #(.CLK_HZ(A_CLK_HZ), .BAUD(A_BAUD), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk_clk(clk), .reset_reset_n(rst_n), .rxd(rxd_a), .rd_bus(bus_a)
  );

  uart_rx_fifo dut_b (
    .clk_clk(clk), .reset_reset_n(rst_n), .rxd(rxd_b), .rd_bus(bus_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] b, input logic stop_bit);
    rxd_a = 1'b0;
    repeat (BIT_A) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_a = b[i];
      repeat (BIT_A) @(negedge clk);
    end
    rxd_a = stop_bit;
    repeat (BIT_A) @(negedge clk);
  endtask

  task automatic send_b(input logic [7:0] b);
    rxd_b = 1'b0;
    repeat (BIT_B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_b = b[i];
      repeat (BIT_B) @(negedge clk);
    end
    rxd_b = 1'b1;
    repeat (BIT_B) @(negedge clk);
  endtask

  // Bad stop bit: keep the line low for a while longer, then return to idle.
  task automatic finish_break_a(input int low_bits);
    repeat (low_bits * BIT_A) @(negedge clk);
    rxd_a = 1'b1;
    repeat (2 * BIT_A) @(negedge clk);
  endtask

  task automatic pop_a();
    bus_a.rd_en = 1'b1;
    @(negedge clk);
    bus_a.rd_en = 1'b0;
  endtask

  task automatic clr_a();
    bus_a.clr_err = 1'b1;
    @(negedge clk);
    bus_a.clr_err = 1'b0;
  endtask

  vec_t tbl[6];

  initial begin
    int n;
    logic [7:0] b;
    logic ok;
    int np;

    tbl[0] = '{8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 1, 1'b0};
    tbl[1] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'h5A, 2, 1'b0};
    tbl[2] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h5A, 2, 1'b1};
    tbl[3] = '{8'h80, 1'b1, 1'b1, 1'b1, 8'hFF, 2, 1'b1};
    tbl[4] = '{8'h01, 1'b1, 1'b1, 1'b1, 8'h80, 2, 1'b1};
    tbl[5] = '{8'h3C, 1'b0, 1'b1, 1'b1, 8'h01, 1, 1'b1};

    bus_a.rd_en = 1'b0; bus_a.clr_err = 1'b0;
    bus_b.rd_en = 1'b0; bus_b.clr_err = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus_a.rd_valid, 0);
    chk("rst_data", bus_a.rd_data, 8'h00);
    chk("rst_count", bus_a.fifo_count, 0);
    chk("rst_frame", bus_a.frame_err, 0);
    chk("rst_overrun", bus_a.overrun_err, 0);
    chk("rst_b_valid", bus_b.rd_valid, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0xA5 at the default 115200 baud
    n = 0;
    fork
      send_b(8'hA5);
      begin
        do begin @(negedge clk); n++; end while (!bus_b.rd_valid && n < 12 * BIT_B);
      end
    join
    chk("a5_latency_ok", (n >= 9 * BIT_B) && (n <= (21 * BIT_B) / 2), 1);
    chk("a5_data", bus_b.rd_data, 8'hA5);
    chk("a5_count", bus_b.fifo_count, 1);
    chk("a5_frame", bus_b.frame_err, 0);
    chk("a5_overrun", bus_b.overrun_err, 0);
    bus_b.rd_en = 1'b1;
    @(negedge clk);
    bus_b.rd_en = 1'b0;
    chk("a5_pop_valid", bus_b.rd_valid, 0);
    chk("a5_pop_count", bus_b.fifo_count, 0);

    // push latency on the fast instance, reused to line up same-cycle events
    fork
      send_a(8'hC3, 1'b1);
      begin
        do begin @(negedge clk); lat_a++; end while (!bus_a.rd_valid && lat_a < 12 * BIT_A);
      end
    join
    chk("lat_ok", (lat_a >= 9 * BIT_A) && (lat_a <= (21 * BIT_A) / 2), 1);
    chk("lat_data", bus_a.rd_data, 8'hC3);
    pop_a();
    chk("lat_pop_valid", bus_a.rd_valid, 0);

    // start-bit glitch of 3 clocks
    rxd_a = 1'b0;
    repeat (3) @(negedge clk);
    rxd_a = 1'b1;
    repeat (2 * BIT_A) @(negedge clk);
    chk("glitch_count", bus_a.fifo_count, 0);
    chk("glitch_frame", bus_a.frame_err, 0);

    // 17 back-to-back bytes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send_a(8'(i), 1'b1);
    repeat (BIT_A) @(negedge clk);
    chk("ovr_count", bus_a.fifo_count, DEPTH);
    chk("ovr_flag", bus_a.overrun_err, 1);
    chk("ovr_frame", bus_a.frame_err, 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovr_pop%0d", i), bus_a.rd_data, i);
      pop_a();
    end
    chk("ovr_empty", bus_a.rd_valid, 0);
    clr_a();
    chk("ovr_clr", bus_a.overrun_err, 0);

    // framing error followed by break, then a good frame
    send_a(8'h3C, 1'b0);
    finish_break_a(2);
    chk("fe_flag", bus_a.frame_err, 1);
    chk("fe_count", bus_a.fifo_count, 0);
    send_a(8'h3C, 1'b1);
    repeat (BIT_A) @(negedge clk);
    chk("fe_next_data", bus_a.rd_data, 8'h3C);
    chk("fe_next_count", bus_a.fifo_count, 1);
    clr_a();
    chk("fe_clr", bus_a.frame_err, 0);
    pop_a();

    // clr_err landing on the framing decision cycle: the new error must survive
    fork
      send_a(8'h55, 1'b0);
      begin
        repeat (lat_a - 1) @(negedge clk);
        bus_a.clr_err = 1'b1;
        @(negedge clk);
        bus_a.clr_err = 1'b0;
      end
    join
    finish_break_a(1);
    chk("fe_set_wins", bus_a.frame_err, 1);
    clr_a();

    // table-driven vectors
    for (int r = 0; r < 6; r++) begin
      send_a(tbl[r].data, tbl[r].stop_ok);
      if (!tbl[r].stop_ok) finish_break_a(1);
      else repeat (BIT_A) @(negedge clk);
      if (tbl[r].do_pop) pop_a();
      chk($sformatf("tbl%0d_valid", r), bus_a.rd_valid, tbl[r].exp_valid);
      chk($sformatf("tbl%0d_data", r), bus_a.rd_data, tbl[r].exp_data);
      chk($sformatf("tbl%0d_count", r), bus_a.fifo_count, tbl[r].exp_count);
      chk($sformatf("tbl%0d_frame", r), bus_a.frame_err, tbl[r].exp_frame);
    end
    pop_a();
    clr_a();
    chk("tbl_drained", bus_a.rd_valid, 0);

    // full FIFO, pop exactly on the push cycle of 0x77
    for (int i = 0; i < 16; i++) send_a(8'h20 + 8'(i), 1'b1);
    repeat (BIT_A) @(negedge clk);
    chk("full_count", bus_a.fifo_count, DEPTH);
    chk("full_head", bus_a.rd_data, 8'h20);
    fork
      send_a(8'h77, 1'b1);
      begin
        repeat (lat_a - 1) @(negedge clk);
        bus_a.rd_en = 1'b1;
        @(negedge clk);
        bus_a.rd_en = 1'b0;
      end
    join
    repeat (BIT_A) @(negedge clk);
    chk("pp_count", bus_a.fifo_count, DEPTH);
    chk("pp_overrun", bus_a.overrun_err, 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("pp_pop%0d", i), bus_a.rd_data, (i < 15) ? (8'h21 + i) : 8'h77);
      pop_a();
    end
    chk("pp_empty", bus_a.rd_valid, 0);

    // reset during data bit 4 of 0x81, with a byte and an error pending
    send_a(8'h11, 1'b1);
    send_a(8'h00, 1'b0);
    finish_break_a(1);
    chk("prerst_count", bus_a.fifo_count, 1);
    chk("prerst_frame", bus_a.frame_err, 1);
    fork
      send_a(8'h81, 1'b1);
      begin
        repeat (5 * BIT_A + BIT_A / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("inrst_valid", bus_a.rd_valid, 0);
        chk("inrst_data", bus_a.rd_data, 8'h00);
        chk("inrst_count", bus_a.fifo_count, 0);
        chk("inrst_frame", bus_a.frame_err, 0);
        chk("inrst_overrun", bus_a.overrun_err, 0);
      end
    join
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BIT_A) @(negedge clk);
    chk("postrst_count0", bus_a.fifo_count, 0);
    send_a(8'h42, 1'b1);
    repeat (BIT_A) @(negedge clk);
    chk("postrst_data", bus_a.rd_data, 8'h42);
    chk("postrst_count", bus_a.fifo_count, 1);
    pop_a();
    chk("postrst_empty", bus_a.rd_valid, 0);

    // randomized frames against a queue model
    mq.delete();
    m_frame = 1'b0;
    m_over  = 1'b0;
    for (int f = 0; f < 28; f++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 7) != 0);
      send_a(b, ok);
      if (!ok) begin
        finish_break_a(1);
        m_frame = 1'b1;
      end else if (mq.size() == DEPTH) begin
        m_over = 1'b1;
      end else begin
        mq.push_back(b);
      end
      repeat ($urandom_range(1, BIT_A)) @(negedge clk);
      chk($sformatf("rnd%0d_count", f), bus_a.fifo_count, mq.size());
      chk($sformatf("rnd%0d_valid", f), bus_a.rd_valid, (mq.size() != 0));
      chk($sformatf("rnd%0d_frame", f), bus_a.frame_err, m_frame);
      chk($sformatf("rnd%0d_overrun", f), bus_a.overrun_err, m_over);
      if (f < 22) np = ($urandom_range(0, 5) == 0) ? 1 : 0;
      else        np = $urandom_range(2, 4);
      for (int k = 0; k < np; k++) begin
        if (mq.size() != 0) begin
          chk($sformatf("rnd%0d_pop", f), bus_a.rd_data, mq[0]);
          void'(mq.pop_front());
        end
        pop_a();
      end
      if ($urandom_range(0, 5) == 0) begin
        clr_a();
        m_frame = 1'b0;
        m_over  = 1'b0;
      end
    end
    while (mq.size() != 0) begin
      chk("rnd_drain", bus_a.rd_data, mq[0]);
      void'(mq.pop_front());
      pop_a();
    end
    chk("rnd_empty", bus_a.rd_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
